mac_tx_arb: RTL

MAC_TX_ARB -- requirements
Module: mac_tx_arb

---
 rtl/mac_tx_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mac_tx_arb.sv
// mac_tx_arb: two-requester round-robin arbiter feeding a MAC TX byte stream
// Ports: clk, rst (sync, active-high); req_i[1:0] frame requests; gnt_o[1:0] one-hot grant;
//   s0_*/s1_* requester byte streams (data, valid, sof, eof);
//   mac_tx_data/valid/sof/eof registered stream to the MAC (no backpressure);
//   busy_o high outside IDLE; underrun_o one-cycle pulse when valid drops mid-frame.
// Build option: define MAC_TX_ARB_PAD_EN to zero-pad frames shorter than 60 bytes.
module mac_tx_arb #(
    parameter int IFG_CYCLES  = 12,
    parameter int GNT_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    input  logic       s0_sof,
    input  logic       s0_eof,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    input  logic       s1_sof,
    input  logic       s1_eof,
    output logic [7:0] mac_tx_data,
    output logic       mac_tx_valid,
    output logic       mac_tx_sof,
    output logic       mac_tx_eof,
    output logic       busy_o,
    output logic       underrun_o
);
    localparam int IW = $clog2(IFG_CYCLES + 2);
    localparam int TW = $clog2(GNT_TIMEOUT + 1);

`ifdef MAC_TX_ARB_PAD_EN
    typedef enum logic [2:0] {IDLE, GRANT, XFER, PAD, IFG} state_t;
`else
    typedef enum logic [2:0] {IDLE, GRANT, XFER, IFG} state_t;
`endif

    state_t      state;
    logic        rr;
    logic [TW-1:0] tmo;
    logic [IW-1:0] ifg_cnt;
    logic [10:0] byte_cnt, cnt_inc, cnt_next;
    logic [7:0]  sd;
    logic        sv, ss, se, win, pad_go;

    always_comb begin
        sv       = gnt_o[1] ? s1_valid : s0_valid;
        ss       = gnt_o[1] ? s1_sof : s0_sof;
        se       = gnt_o[1] ? s1_eof : s0_eof;
        sd       = gnt_o[1] ? s1_data : s0_data;
        // rr names the requester that wins a tie
        win      = &req_i ? rr : req_i[1];
        cnt_inc  = &byte_cnt ? byte_cnt : byte_cnt + 11'd1;
        cnt_next = (state == GRANT) ? 11'd1 : cnt_inc;
`ifdef MAC_TX_ARB_PAD_EN
        pad_go   = cnt_next < 11'd60;
`else
        pad_go   = 1'b0;
`endif
    end

    assign busy_o = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt_o        <= '0;
            rr           <= 1'b0;
            tmo          <= '0;
            ifg_cnt      <= '0;
            byte_cnt     <= '0;
            mac_tx_data  <= '0;
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            mac_tx_valid <= 1'b0;
            mac_tx_sof   <= 1'b0;
            mac_tx_eof   <= 1'b0;
            underrun_o   <= 1'b0;
            case (state)
                IDLE: if (|req_i) begin
                    gnt_o <= win ? 2'b10 : 2'b01;
                    rr    <= ~win;
                    tmo   <= '0;
                    state <= GRANT;
                end
                GRANT, XFER: begin
                    if (state == GRANT && !(sv && ss)) begin
                        if (tmo == TW'(GNT_TIMEOUT - 1)) begin
                            gnt_o <= '0;
                            state <= IDLE;
                        end else
                            tmo <= tmo + 1'b1;
                    end else if (!sv) begin
                        // the last real byte left one cycle ago, so the gap count starts at 1
                        underrun_o <= 1'b1;
                        gnt_o      <= '0;
                        ifg_cnt    <= IW'(1);
                        state      <= IFG;
                    end else begin
                        mac_tx_data  <= sd;
                        mac_tx_valid <= 1'b1;
                        mac_tx_sof   <= state == GRANT;
                        mac_tx_eof   <= se && !pad_go;
                        byte_cnt     <= cnt_next;
                        if (se) begin
                            gnt_o   <= '0;
                            ifg_cnt <= '0;
`ifdef MAC_TX_ARB_PAD_EN
                            state   <= pad_go ? PAD : IFG;
`else
                            state   <= IFG;
`endif
                        end else
                            state <= XFER;
                    end
                end
`ifdef MAC_TX_ARB_PAD_EN
                PAD: begin
                    mac_tx_data  <= '0;
                    mac_tx_valid <= 1'b1;
                    mac_tx_eof   <= byte_cnt == 11'd59;
                    byte_cnt     <= cnt_inc;
                    if (byte_cnt == 11'd59) begin
                        ifg_cnt <= '0;
                        state   <= IFG;
                    end
                end
`endif
                IFG: if (ifg_cnt == IW'(IFG_CYCLES))
                    state <= IDLE;
                else
                    ifg_cnt <= ifg_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
